// File: rtl/seq_alu_pkg.sv
// Purpose : shared opcode constants, FSM state type and small helpers for seq_alu.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: OPC_* opcode encodings, state_t (IDLE/MUL), is_adder_op().
package seq_alu_pkg;

  localparam logic [2:0] OPC_NEG   = 3'd0;  // ~A + 1
  localparam logic [2:0] OPC_INC   = 3'd1;  // A + 1
  localparam logic [2:0] OPC_ADDC  = 3'd2;  // A + B + carry-in
  localparam logic [2:0] OPC_ADDSH = 3'd3;  // A + (B >>> 1)
  localparam logic [2:0] OPC_AND   = 3'd4;  // A & B
  localparam logic [2:0] OPC_OR    = 3'd5;  // A | B
  localparam logic [2:0] OPC_PACK  = 3'd6;  // {A low half, B low half}
  localparam logic [2:0] OPC_MUL   = 3'd7;  // signed A * B, multi-cycle

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  // Opcodes 0..3 share the single adder and produce carry/overflow from it.
  function automatic logic is_adder_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Purpose : sequential radix-2 Booth multiplier, one partial-product step per enabled cycle.
// Latency : WIDTH steps after i_start; o_prod is the product *after* the step being taken while o_done=1.
// Backpressure : the owner withholds i_step to freeze the multiplier (used to stall on the final step).
// Ports: clk, i_clr (sync clear), i_start/i_a/i_b (load operands), i_step (advance one step),
//        o_done (final step pending this cycle), o_prod (2*WIDTH-bit signed product).
module seq_alu_mul
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 i_clr,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_step,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_prod
);

  localparam int CW = $clog2(WIDTH);

  // Accumulator is one bit wider than the operands so that subtracting the
  // most negative multiplicand cannot wrap before the arithmetic shift.
  logic signed [WIDTH:0]   r_acc;
  logic signed [WIDTH:0]   r_m;
  logic [WIDTH-1:0]        r_q;
  logic                    r_q1;
  logic [CW-1:0]           r_cnt;

  logic signed [WIDTH:0]   w_sum;
  logic [WIDTH:0]          w_acc_nxt;
  logic [WIDTH-1:0]        w_q_nxt;

  // Booth recoding on {Q[0], Q[-1]}: 01 adds M, 10 subtracts M, else no-op;
  // then {acc, Q} shifts right arithmetically by one.
  always_comb begin
    w_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
    w_acc_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
  end

  assign o_done = (r_cnt == CW'(WIDTH - 1));
  // Lookahead product so the owner can capture the result on the final step edge.
  assign o_prod = {w_acc_nxt[WIDTH-1:0], w_q_nxt};

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_acc <= '0;
      r_m   <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_acc <= '0;
      r_m   <= {i_a[WIDTH-1], i_a};
      r_q   <= i_b;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      r_q1  <= r_q[0];
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Purpose : registered ALU (negate/inc/add-carry/add-shift/and/or/pack) plus multi-cycle signed multiply.
// Latency : ops 0-6 one cycle from accept; op 7 WIDTH cycles from accept.
// Backpressure : in_ready drops while a result is held undrained or a multiply is running.
// Ports: clk, rst (sync, active high); in_valid/in_ready with inA, inB, inC, opc;
//        out_valid/out_ready with outW, zer, neg, cout, ovf; busy while multiplying.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  inA,
  input  logic [WIDTH-1:0]  inB,
  input  logic              inC,
  input  logic [2:0]        opc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  outW,
  output logic              zer,
  output logic              neg,
  output logic              cout,
  output logic              ovf,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_outW;
  logic                r_zer;
  logic                r_neg;
  logic                r_cout;
  logic                r_ovf;

  logic                w_out_free;
  logic                w_accept;
  logic                w_mul_start;
  logic                w_mul_step;
  logic                w_mul_done;
  logic                w_load_alu;
  logic                w_load_mul;
  logic                w_load;
  logic [2*WIDTH-1:0]  w_prod;
  logic                w_mul_ovf;

  logic [WIDTH-1:0]    w_add_x;
  logic [WIDTH-1:0]    w_add_y;
  logic                w_add_cin;
  logic [WIDTH:0]      w_add_sum;

  logic [WIDTH-1:0]    w_alu_res;
  logic                w_alu_cout;
  logic                w_alu_ovf;

  logic [WIDTH-1:0]    w_res;
  logic                w_res_cout;
  logic                w_res_ovf;

  // Output register is free if empty or being drained this cycle.
  assign w_out_free = ~r_out_valid | out_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_accept    = 1'b0;
    w_mul_start = 1'b0;
    w_mul_step  = 1'b0;
    w_load_alu  = 1'b0;
    w_load_mul  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst & w_out_free;
        w_accept = in_valid & in_ready;
        if (w_accept) begin
          if (opc == OPC_MUL) begin
            w_mul_start = 1'b1;
            w_state_nxt = MUL;
          end else begin
            w_load_alu = 1'b1;
          end
        end
      end
      MUL: begin
        // Intermediate steps always advance; the final step waits for a free
        // output register so an undrained result is never overwritten.
        w_mul_step = ~w_mul_done | w_out_free;
        if (w_mul_done & w_out_free) begin
          w_load_mul  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load = w_load_alu | w_load_mul;

  // ---------------- Multiplier ----------------
  seq_alu_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .i_clr   (rst),
    .i_start (w_mul_start),
    .i_a     (inA),
    .i_b     (inB),
    .i_step  (w_mul_step),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  // The low half is a valid signed result only if the upper W+1 product bits
  // are a pure sign extension.
  assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

  // ---------------- Shared adder operand muxing ----------------
  always_comb begin
    w_add_x   = inA;
    w_add_y   = '0;
    w_add_cin = 1'b0;
    case (opc)
      OPC_NEG: begin
        w_add_x   = ~inA;
        w_add_cin = 1'b1;
      end
      OPC_INC: begin
        w_add_cin = 1'b1;
      end
      OPC_ADDC: begin
        w_add_y   = inB;
        w_add_cin = inC;
      end
      OPC_ADDSH: begin
        w_add_y = {inB[WIDTH-1], inB[WIDTH-1:1]};
      end
      default: begin
        w_add_x   = inA;
        w_add_y   = '0;
        w_add_cin = 1'b0;
      end
    endcase
  end

  assign w_add_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};

  // ---------------- Single-cycle result and flags ----------------
  always_comb begin
    w_alu_res  = w_add_sum[WIDTH-1:0];
    w_alu_cout = 1'b0;
    w_alu_ovf  = 1'b0;
    if (is_adder_op(opc)) begin
      w_alu_cout = w_add_sum[WIDTH];
      w_alu_ovf  = (w_add_x[WIDTH-1] == w_add_y[WIDTH-1]) &
                   (w_add_sum[WIDTH-1] != w_add_x[WIDTH-1]);
    end else begin
      case (opc)
        OPC_AND:  w_alu_res = inA & inB;
        OPC_OR:   w_alu_res = inA | inB;
        OPC_PACK: w_alu_res = {inA[WIDTH/2-1:0], inB[WIDTH/2-1:0]};
        default:  w_alu_res = '0;
      endcase
    end
  end

  always_comb begin
    w_res      = w_alu_res;
    w_res_cout = w_alu_cout;
    w_res_ovf  = w_alu_ovf;
    if (w_load_mul) begin
      w_res      = w_prod[WIDTH-1:0];
      w_res_cout = 1'b0;
      w_res_ovf  = w_mul_ovf;
    end
  end

  // ---------------- Output registers ----------------
  // zer/neg are captured alongside outW so they track it exactly, yet read 0
  // out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_outW      <= '0;
      r_zer       <= 1'b0;
      r_neg       <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_outW      <= w_res;
      r_zer       <= (w_res == '0);
      r_neg       <= w_res[WIDTH-1];
      r_cout      <= w_res_cout;
      r_ovf       <= w_res_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign outW      = r_outW;
  assign zer       = r_zer;
  assign neg       = r_neg;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign busy      = (r_state == MUL);

endmodule

// File: tb/tb_seq_alu.sv
// Purpose : self-checking bench for seq_alu: directed literal cases plus randomized traffic vs a math model.
// Latency : model expects results 1 edge (ops 0-6) or WIDTH edges (op 7) after accept.
// Backpressure : out_ready is randomly dropped; bench checks hold/stall behaviour every cycle.
module tb_seq_alu;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  inA = '0;
  logic [W-1:0]  inB = '0;
  logic          inC = 1'b0;
  logic [2:0]    opc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  outW;
  logic          zer, neg, cout, ovf, busy;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inA       (inA),
    .inB       (inB),
    .inC       (inC),
    .opc       (opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outW      (outW),
    .zer       (zer),
    .neg       (neg),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  logic mon_en   = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t q[$];

  task automatic chkw(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=0x%0h want=0x%0h", name, $time, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands' numeric values.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic c);
    exp_t   e;
    longint ua, ub, sa, sb, s, u, y, smax, smin, umod;
    umod = longint'(1) << W;
    smax = (longint'(1) << (W-1)) - 1;
    smin = -(longint'(1) << (W-1));
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0; u = 0; y = 0;
    e.res = '0; e.cout = 1'b0; e.ovf = 1'b0; e.due = 0;
    case (op)
      3'd0: begin
        s = -sa;
        e.res = s[W-1:0];
        e.cout = (a == '0);
        e.ovf = (s > smax);
      end
      3'd1: begin
        s = sa + 1; u = ua + 1;
        e.res = u[W-1:0];
        e.cout = (u >= umod);
        e.ovf = (s > smax);
      end
      3'd2: begin
        s = sa + sb + longint'(c); u = ua + ub + longint'(c);
        e.res = u[W-1:0];
        e.cout = (u >= umod);
        e.ovf = (s > smax) || (s < smin);
      end
      3'd3: begin
        y = sb >>> 1;
        s = sa + y; u = ua + (y & (umod - 1));
        e.res = u[W-1:0];
        e.cout = (u >= umod);
        e.ovf = (s > smax) || (s < smin);
      end
      3'd4: e.res = a & b;
      3'd5: e.res = a | b;
      3'd6: e.res = {a[W/2-1:0], b[W/2-1:0]};
      default: begin
        s = sa * sb;
        e.res = s[W-1:0];
        e.ovf = (s > smax) || (s < smin);
      end
    endcase
    return e;
  endfunction

  // Signals sampled mid-cycle, consumed by the edge process.
  logic          s_rst = 1'b1;
  logic          s_acc = 1'b0;
  logic          s_pop = 1'b0;
  logic          s_c   = 1'b0;
  logic [2:0]    s_op  = '0;
  logic [W-1:0]  s_a   = '0;
  logic [W-1:0]  s_b   = '0;

  task automatic cmp_cycle();
    if (q.size() > 0 && q[0].due <= edge_n) begin
      chk1("out_valid", out_valid, 1'b1);
      chkw("outW", outW, q[0].res);
      chk1("cout", cout, q[0].cout);
      chk1("ovf", ovf, q[0].ovf);
      chk1("zer", zer, q[0].res == '0);
      chk1("neg", neg, q[0].res[W-1]);
      chk1("busy_done", busy, 1'b0);
      if (!out_ready) chk1("in_ready_stall", in_ready, 1'b0);
      else            chk1("in_ready_drain", in_ready, !rst);
    end else if (q.size() > 0) begin
      chk1("out_valid_mul", out_valid, 1'b0);
      chk1("busy_mul", busy, 1'b1);
      chk1("in_ready_mul", in_ready, 1'b0);
    end else begin
      chk1("out_valid_idle", out_valid, 1'b0);
      chk1("busy_idle", busy, 1'b0);
      chk1("in_ready_idle", in_ready, !rst);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) cmp_cycle();
    s_rst = rst;
    s_acc = in_valid & in_ready;
    s_pop = out_valid & out_ready;
    s_op  = opc;
    s_a   = inA;
    s_b   = inB;
    s_c   = inC;
  end

  always @(posedge clk) begin : edge_proc
    exp_t e;
    edge_n++;
    if (s_rst) begin
      q.delete();
    end else begin
      if (s_pop && q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
      if (s_acc) begin
        e = model(s_op, s_a, s_b, s_c);
        e.due = (s_op == 3'd7) ? edge_n + W : edge_n;
        q.push_back(e);
      end
    end
  end

  // Present an op and hold it until accepted; returns just after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    int   n = 0;
    logic done = 1'b0;
    in_valid = 1'b1; opc = op; inA = a; inB = b; inC = c;
    while (!done && n < 100) begin
      @(posedge clk);
      done = s_acc;
      n++;
      #1;
    end
    in_valid = 1'b0;
    chk1("issue_accepted", done, 1'b1);
  endtask

  task automatic mul_test(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic z, input logic v);
    issue(3'd7, a, b, 1'b0);
    inA = W'($urandom);
    inB = W'($urandom);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk1("mul_busy", busy, 1'b1);
      chk1("mul_in_ready", in_ready, 1'b0);
      chk1("mul_early", out_valid, 1'b0);
    end
    @(negedge clk);
    chk1("mul_valid", out_valid, 1'b1);
    chkw("mul_outW", outW, res);
    chk1("mul_zer", zer, z);
    chk1("mul_ovf", ovf, v);
    chk1("mul_cout", cout, 1'b0);
    chk1("mul_busy_end", busy, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_outW", outW, '0);
    chk1("rst_flags", zer | neg | cout | ovf, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);

    issue(3'd2, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    chk1("addc_valid", out_valid, 1'b1);
    chkw("addc_outW", outW, 16'h8000);
    chk1("addc_neg", neg, 1'b1);
    chk1("addc_ovf", ovf, 1'b1);
    chk1("addc_cout", cout, 1'b0);
    chk1("addc_zer", zer, 1'b0);

    issue(3'd0, 16'h0000, 16'h1234, 1'b0);
    @(negedge clk);
    chkw("neg0_outW", outW, 16'h0000);
    chk1("neg0_zer", zer, 1'b1);
    chk1("neg0_cout", cout, 1'b1);
    chk1("neg0_ovf", ovf, 1'b0);

    issue(3'd0, 16'h8000, 16'h0000, 1'b0);
    @(negedge clk);
    chkw("negmin_outW", outW, 16'h8000);
    chk1("negmin_ovf", ovf, 1'b1);

    issue(3'd3, 16'h0010, 16'hFFF0, 1'b0);
    @(negedge clk);
    chkw("addsh_outW", outW, 16'h0008);
    chk1("addsh_cout", cout, 1'b1);

    issue(3'd6, 16'h12AB, 16'h34CD, 1'b0);
    @(negedge clk);
    chkw("pack_outW", outW, 16'hABCD);

    // Backpressure: hold the AND result, offer an OR that must wait for the drain.
    issue(3'd4, 16'hF0F0, 16'hFF00, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; opc = 3'd5; inA = 16'h0F0F; inB = 16'h00F0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("bp_valid", out_valid, 1'b1);
      chkw("bp_outW", outW, 16'hF000);
      chk1("bp_neg", neg, 1'b1);
      chk1("bp_other_flags", zer | cout | ovf, 1'b0);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    chk1("bp_drain_accept", s_acc, 1'b1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk1("bp_next_valid", out_valid, 1'b1);
    chkw("bp_next_outW", outW, 16'h0FFF);

    mul_test(16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b0);

    // Reset in the middle of a multiply.
    issue(3'd7, 16'h1234, 16'h5678, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk1("mrst_out_valid", out_valid, 1'b0);
    chkw("mrst_outW", outW, '0);
    chk1("mrst_flags", zer | neg | cout | ovf, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("mrst_in_ready_after", in_ready, 1'b1);
    for (int k = 0; k < 2*W; k++) begin
      @(negedge clk);
      chk1("mrst_no_stale", out_valid, 1'b0);
    end
    mul_test(16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
    issue(3'd1, 16'h0041, 16'h0000, 1'b0);
    @(negedge clk);
    chkw("inc_outW", outW, 16'h0042);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 499) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      opc       = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      inA       = pick();
      inB       = pick();
      inC       = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3*W) @(posedge clk);
    @(negedge clk);
    chk1("final_drained", q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
